// File: rtl/frogger_lane_engine.sv
// rtl/frogger_lane_engine.sv - Frogger obstacle-lane engine: wrapping car lanes, tile queries, collision detect
module frogger_lane_engine #(
    parameter int NUM_LANES = 10,
    parameter int GRID_W    = 20,
    parameter int COORD_W   = 6,
    parameter int SPEED_W   = 4,
    parameter int CAR_LEN   = 2,
    parameter int TICK_DIV  = 2000000,
    parameter logic [NUM_LANES-1:0] LANE_DIR = 10'b1010101010,
    parameter logic [NUM_LANES*COORD_W-1:0] LANE_Y =
        {6'd12, 6'd11, 6'd10, 6'd9, 6'd8, 6'd5, 6'd4, 6'd3, 6'd2, 6'd1}
) (
    input  logic                           i_Clk,
    input  logic                           i_Reset,
    input  logic                           i_Enable,
    input  logic                           i_Restart,
    input  logic [NUM_LANES*SPEED_W-1:0]   i_Speed,
    input  logic [COORD_W-1:0]             i_Frog_X,
    input  logic [COORD_W-1:0]             i_Frog_Y,
    input  logic [COORD_W-1:0]             i_Query_X,
    input  logic [COORD_W-1:0]             i_Query_Y,
    output logic                           o_Query_Hit,
    output logic [3:0]                     o_Query_Lane,
    output logic                           o_Collision,
    output logic                           o_Overlap,
    output logic                           o_Tick,
    output logic [NUM_LANES*COORD_W-1:0]   o_Lane_X
);

    localparam int PRE_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0]   PRE_LAST = PRE_W'(TICK_DIV - 1);
    localparam logic [COORD_W-1:0] X_MAX    = COORD_W'(GRID_W - 1);
    localparam logic [COORD_W:0]   GRID_WX  = (COORD_W + 1)'(GRID_W);
    localparam logic [COORD_W:0]   CAR_LENX = (COORD_W + 1)'(CAR_LEN);

    logic [PRE_W-1:0]   presc;
    logic               tick_now;
    logic [COORD_W-1:0] lane_x   [NUM_LANES];
    logic [COORD_W-1:0] x_nxt    [NUM_LANES];
    logic [SPEED_W-1:0] step_cnt [NUM_LANES];
    logic [SPEED_W-1:0] cnt_nxt  [NUM_LANES];
    logic               query_hit_nxt;
    logic [3:0]         query_lane_nxt;
    logic               overlap_nxt;

    function automatic logic [COORD_W-1:0] init_x(input int n);
        return COORD_W'((3 * n) % GRID_W);
    endfunction

    function automatic logic [COORD_W-1:0] move_x(input logic [COORD_W-1:0] x, input logic right);
        if (right)
            return (x == X_MAX) ? '0 : x + 1'b1;
        else
            return (x == '0) ? X_MAX : x - 1'b1;
    endfunction

    // A tile is covered when its wrapped distance behind the head is below CAR_LEN.
    function automatic logic covers(input logic [COORD_W-1:0] head, input logic right,
                                    input logic [COORD_W-1:0] row,
                                    input logic [COORD_W-1:0] qx, input logic [COORD_W-1:0] qy);
        logic [COORD_W:0] a;
        logic [COORD_W:0] b;
        logic [COORD_W:0] d;
        a = right ? {1'b0, head} : {1'b0, qx};
        b = right ? {1'b0, qx} : {1'b0, head};
        d = (a >= b) ? (a - b) : (a + GRID_WX - b);
        return (qy == row) && ({1'b0, qx} < GRID_WX) && (d < CAR_LENX);
    endfunction

    assign tick_now = i_Enable && (presc == PRE_LAST);

    always_comb begin
        for (int n = 0; n < NUM_LANES; n++) begin
            x_nxt[n]   = lane_x[n];
            cnt_nxt[n] = step_cnt[n];
            if (i_Speed[n*SPEED_W +: SPEED_W] == '0) begin
                cnt_nxt[n] = '0;
            end else if (step_cnt[n] >= i_Speed[n*SPEED_W +: SPEED_W] - 1'b1) begin
                // >= rather than == so a speed lowered mid-count moves on the next tick
                cnt_nxt[n] = '0;
                x_nxt[n]   = move_x(lane_x[n], LANE_DIR[n]);
            end else begin
                cnt_nxt[n] = step_cnt[n] + 1'b1;
            end
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset || i_Restart) begin
            presc  <= '0;
            o_Tick <= 1'b0;
            for (int n = 0; n < NUM_LANES; n++) begin
                lane_x[n]   <= init_x(n);
                step_cnt[n] <= '0;
            end
        end else begin
            o_Tick <= tick_now;
            if (i_Enable)
                presc <= tick_now ? '0 : presc + 1'b1;
            if (tick_now) begin
                for (int n = 0; n < NUM_LANES; n++) begin
                    lane_x[n]   <= x_nxt[n];
                    step_cnt[n] <= cnt_nxt[n];
                end
            end
        end
    end

    always_comb begin
        query_hit_nxt  = 1'b0;
        query_lane_nxt = '0;
        overlap_nxt    = 1'b0;
        // Descending scan so the lowest matching lane is the one left standing.
        for (int n = NUM_LANES - 1; n >= 0; n--) begin
            if (covers(lane_x[n], LANE_DIR[n], LANE_Y[n*COORD_W +: COORD_W], i_Query_X, i_Query_Y)) begin
                query_hit_nxt  = 1'b1;
                query_lane_nxt = 4'(n);
            end
            if (covers(lane_x[n], LANE_DIR[n], LANE_Y[n*COORD_W +: COORD_W], i_Frog_X, i_Frog_Y))
                overlap_nxt = 1'b1;
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            o_Query_Hit  <= 1'b0;
            o_Query_Lane <= '0;
            o_Overlap    <= 1'b0;
            o_Collision  <= 1'b0;
        end else begin
            o_Query_Hit  <= query_hit_nxt;
            o_Query_Lane <= query_lane_nxt;
            o_Overlap    <= overlap_nxt;
            o_Collision  <= overlap_nxt & ~o_Overlap;
        end
    end

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane_out
        assign o_Lane_X[g*COORD_W +: COORD_W] = lane_x[g];
    end

endmodule

// File: tb/tb_frogger_lane_engine.sv
// tb/tb_frogger_lane_engine.sv - randomized bench for frogger_lane_engine against a tile-level lane model
module tb_frogger_lane_engine;

    localparam int NL = 10;
    localparam int GW = 20;
    localparam int CW = 6;
    localparam int SW = 4;
    localparam int CL = 2;
    localparam int TD = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset, enable, restart;
    logic [NL*SW-1:0] speed;
    logic [CW-1:0]    frog_x, frog_y, query_x, query_y;
    logic             query_hit, collision, overlap, tick;
    logic [3:0]       query_lane;
    logic [NL*CW-1:0] lane_x_bus;

    frogger_lane_engine #(
        .NUM_LANES(NL), .GRID_W(GW), .COORD_W(CW), .SPEED_W(SW), .CAR_LEN(CL), .TICK_DIV(TD)
    ) dut (
        .i_Clk(clk), .i_Reset(reset), .i_Enable(enable), .i_Restart(restart), .i_Speed(speed),
        .i_Frog_X(frog_x), .i_Frog_Y(frog_y), .i_Query_X(query_x), .i_Query_Y(query_y),
        .o_Query_Hit(query_hit), .o_Query_Lane(query_lane), .o_Collision(collision),
        .o_Overlap(overlap), .o_Tick(tick), .o_Lane_X(lane_x_bus)
    );

    int errors = 0;
    int checks = 0;

    int lane_row [NL] = '{1, 2, 3, 4, 5, 8, 9, 10, 11, 12};

    int mx [NL];
    int mcnt [NL];
    int mpresc = 0;
    bit mtick = 0, mhit = 0, mov = 0, mcoll = 0;
    int mlane = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int dut_x(input int n);
        return int'(lane_x_bus[n*CW +: CW]);
    endfunction

    function automatic bit lane_right(input int n);
        return (n % 2) == 1;
    endfunction

    // Enumerate the tiles a car sits on and see whether (qx,qy) is one of them.
    function automatic bit occ(input int n, input int qx, input int qy);
        int t;
        if (qy != lane_row[n]) return 0;
        for (int k = 0; k < CL; k++) begin
            t = lane_right(n) ? (mx[n] - k + GW) % GW : (mx[n] + k) % GW;
            if (t == qx) return 1;
        end
        return 0;
    endfunction

    task automatic cycle();
        bit nh, nov;
        int nl, s;
        logic [NL*CW-1:0] eb;
        nh = 0; nl = 0; nov = 0;
        for (int n = NL - 1; n >= 0; n--)
            if (occ(n, int'(query_x), int'(query_y))) begin nh = 1; nl = n; end
        for (int n = 0; n < NL; n++)
            if (occ(n, int'(frog_x), int'(frog_y))) nov = 1;
        if (reset) begin
            mhit = 0; mlane = 0; mov = 0; mcoll = 0;
        end else begin
            mcoll = nov && !mov; mov = nov; mhit = nh; mlane = nl;
        end
        if (reset || restart) begin
            mpresc = 0; mtick = 0;
            for (int n = 0; n < NL; n++) begin mx[n] = (3 * n) % GW; mcnt[n] = 0; end
        end else if (enable && mpresc == TD - 1) begin
            mpresc = 0; mtick = 1;
            for (int n = 0; n < NL; n++) begin
                s = int'(speed[n*SW +: SW]);
                if (s == 0) mcnt[n] = 0;
                else if (mcnt[n] + 1 >= s) begin
                    mcnt[n] = 0;
                    mx[n] = lane_right(n) ? (mx[n] + 1) % GW : (mx[n] + GW - 1) % GW;
                end else mcnt[n] = mcnt[n] + 1;
            end
        end else begin
            if (enable) mpresc = mpresc + 1;
            mtick = 0;
        end
        @(posedge clk);
        #1;
        for (int n = 0; n < NL; n++) eb[n*CW +: CW] = CW'(mx[n]);
        check("tick", 64'(tick), 64'(mtick));
        check("lane_x", 64'(lane_x_bus), 64'(eb));
        check("query_hit", 64'(query_hit), 64'(mhit));
        if (mhit) check("query_lane", 64'(query_lane), 64'(mlane));
        check("overlap", 64'(overlap), 64'(mov));
        check("collision", 64'(collision), 64'(mcoll));
    endtask

    initial begin
        int k, coll_cnt, ov_cnt, tick_cnt;
        logic [NL*CW-1:0] held;
        for (int n = 0; n < NL; n++) begin mx[n] = 0; mcnt[n] = 0; end
        reset = 1; enable = 1; restart = 0;
        speed = {NL{4'd1}};
        frog_x = 0; frog_y = 0; query_x = 0; query_y = 0;
        cycle(); cycle();
        reset = 0;
        check("rst_lane0", 64'(dut_x(0)), 64'd0);
        check("rst_lane1", 64'(dut_x(1)), 64'd3);
        check("rst_hit", 64'(query_hit), 64'd0);
        check("rst_lane", 64'(query_lane), 64'd0);

        k = 0;
        while (!tick && k < 20) begin cycle(); k++; end
        check("first_tick_seen", 64'(tick), 64'd1);
        check("t1_lane0_left", 64'(dut_x(0)), 64'd19);
        check("t1_lane1_right", 64'(dut_x(1)), 64'd4);

        restart = 1; cycle(); restart = 0;
        speed[1*SW +: SW] = 4'd3;
        speed[2*SW +: SW] = 4'd0;
        tick_cnt = 0; k = 0;
        while (tick_cnt < 9 && k < 100) begin cycle(); tick_cnt += int'(tick); k++; end
        check("t2_ticks", 64'(tick_cnt), 64'd9);
        check("t2_lane1_speed3", 64'(dut_x(1)), 64'd6);
        check("t2_lane2_frozen", 64'(dut_x(2)), 64'd6);

        speed[1*SW +: SW] = 4'd1;
        k = 0;
        while (dut_x(1) != 0 && k < 200) begin cycle(); k++; end
        check("t3_wrap_to_0", 64'(dut_x(1)), 64'd0);
        query_x = 0; query_y = 2; cycle();
        check("t3_q0_hit", 64'(query_hit), 64'd1);
        check("t3_q0_lane", 64'(query_lane), 64'd1);
        query_x = 19; cycle();
        check("t3_q19_hit", 64'(query_hit), 64'd1);
        check("t3_q19_lane", 64'(query_lane), 64'd1);
        query_x = 20; cycle();
        check("t3_q20_nohit", 64'(query_hit), 64'd0);

        restart = 1; cycle(); restart = 0;
        speed = '0;
        speed[1*SW +: SW] = 4'd1;
        frog_x = 5; frog_y = 2;
        coll_cnt = 0; ov_cnt = 0; k = 0;
        while (dut_x(1) != 8 && k < 200) begin
            cycle(); coll_cnt += int'(collision); ov_cnt += int'(overlap); k++;
        end
        check("t4_reached_8", 64'(dut_x(1)), 64'd8);
        check("t4_one_pulse", 64'(coll_cnt), 64'd1);
        check("t4_overlap_len", 64'(ov_cnt), 64'd8);

        restart = 1; cycle(); restart = 0;
        speed = {NL{4'd1}};
        cycle(); cycle();
        enable = 0;
        held = lane_x_bus; tick_cnt = 0;
        for (int i = 0; i < 50; i++) begin cycle(); tick_cnt += int'(tick); end
        check("t5_no_tick", 64'(tick_cnt), 64'd0);
        check("t5_x_held", 64'(lane_x_bus), 64'(held));
        enable = 1; k = 0;
        do begin cycle(); k++; end while (!tick && k < 20);
        check("t5_resume_latency", 64'(k), 64'd2);

        for (int pass = 0; pass < 2; pass++) begin
            k = 0;
            do begin cycle(); k++; end while (!tick && k < 20);
            cycle(); cycle(); cycle();
            if (pass == 0) restart = 1; else reset = 1;
            cycle();
            restart = 0; reset = 0;
            check("t6_lane0", 64'(dut_x(0)), 64'd0);
            check("t6_lane1", 64'(dut_x(1)), 64'd3);
            check("t6_no_tick", 64'(tick), 64'd0);
        end

        for (int i = 0; i < 2500; i++) begin
            enable  = ($urandom % 16) != 0;
            restart = ($urandom % 200) == 0;
            reset   = ($urandom % 400) == 0;
            query_x = CW'($urandom_range(0, 22));
            query_y = CW'($urandom_range(0, 13));
            if ($urandom % 8 == 0) begin
                frog_x = CW'($urandom_range(0, 21));
                frog_y = CW'($urandom_range(0, 13));
            end
            for (int n = 0; n < NL; n++)
                if ($urandom % 60 == 0)
                    speed[n*SW +: SW] = ($urandom % 4 == 0) ? SW'($urandom_range(0, 15))
                                                            : SW'($urandom_range(0, 3));
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
